page_packet_reader: RTL

- Read-side consumer of the spectrum page RAM: the receiver of the start/busy handshake issued by the page writer.
- On start, it reads one 512-byte page through addrb_l/power_out and frames the bytes into a packet on a byte-wide valid/ready stream toward the Ethernet MAC.
- Packet layout: 14-byte header, then 512 payload bytes.
- Fully in the rd_clk domain.

---
 rtl/page_packet_reader.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/page_packet_reader.sv
// page_packet_reader: read-side consumer of the spectrum page RAM.
// When the page writer raises start, this block reads one page through
// addrb_l/power_out and sends it to the MAC on a byte-wide valid/ready
// stream. Each packet is a 14-byte header followed by the page payload.
module page_packet_reader #(
  parameter int PAGE_BYTES = 512,
  parameter int FIFO_DEPTH = 4,
  parameter int IDLE_GAP   = 4
) (
  input  logic                          rd_clk,
  input  logic                          rst,
  input  logic                          start,
  output logic                          busy,
  output logic [$clog2(PAGE_BYTES)-1:0] addrb_l,
  input  logic [7:0]                    power_out,
  input  logic [63:0]                   user_data,
  input  logic [15:0]                   page_read,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          tx_sof,
  output logic                          tx_eof
);

  localparam int AW        = $clog2(PAGE_BYTES);
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int CW        = PW + 1;
  localparam int GW        = $clog2(IDLE_GAP + 1);
  localparam int HDR_BYTES = 14;
  localparam int HW        = HDR_BYTES * 8;

  typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

  // Packet framing state
  state_t        state;
  logic [63:0]   ud_lat;
  logic [15:0]   pg_lat;
  logic [31:0]   seq_cnt;
  logic [3:0]    hdr_idx;
  logic [AW:0]   pay_cnt;
  logic [GW-1:0] gap_cnt;

  // Prefetch engine state. rd_v1 marks an address that is on addrb_l this
  // cycle; rd_v2 marks that its data is on power_out this cycle.
  logic [AW:0]   issue_ptr;
  logic          rd_v1;
  logic          rd_v2;

  // Prefetch FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] fifo_count;

  logic          fifo_empty;
  logic          accept;
  logic          fifo_push;
  logic          fifo_pop;
  logic          issue;
  logic [CW-1:0] credit_used;
  logic [HW-1:0] hdr_vec;
  logic [HW-1:0] hdr_shift;

  assign fifo_empty  = (fifo_count == '0);
  assign accept      = tx_valid && tx_ready;
  assign fifo_pop    = (state == PAY) && accept;
  assign fifo_push   = rd_v2;
  assign hdr_vec     = {ud_lat, pg_lat, seq_cnt};

  // Credits count both buffered bytes and reads still travelling through
  // the RAM, so a push always has a free slot waiting for it.
  assign credit_used = fifo_count + CW'(rd_v1) + CW'(rd_v2);
  assign issue       = ((state == HDR) || (state == PAY))
                       && (issue_ptr < (AW+1)'(PAGE_BYTES))
                       && (credit_used < CW'(FIFO_DEPTH));

  // Packet sequencer: latches the header fields, counts header/payload
  // accepts, drives busy and times the inter-packet gap.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      ud_lat  <= '0;
      pg_lat  <= '0;
      seq_cnt <= '0;
      hdr_idx <= '0;
      pay_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      unique case (state)
        IDLE: begin
          if (start) begin
            ud_lat  <= user_data;
            pg_lat  <= page_read;
            hdr_idx <= '0;
            pay_cnt <= '0;
            busy    <= 1'b1;
            state   <= HDR;
          end
        end
        HDR: begin
          if (accept) begin
            if (hdr_idx == 4'(HDR_BYTES - 1)) begin
              state <= PAY;
            end else begin
              hdr_idx <= hdr_idx + 1'b1;
            end
          end
        end
        PAY: begin
          if (accept) begin
            pay_cnt <= pay_cnt + 1'b1;
            if (pay_cnt == (AW+1)'(PAGE_BYTES - 1)) begin
              seq_cnt <= seq_cnt + 1'b1;
              busy    <= 1'b0;
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GW'(IDLE_GAP - 1)) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Prefetch engine: issues each page offset once, in order, and parks
  // addrb_l at 0 right after 511 so the writer sees 511 for one cycle only.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      issue_ptr <= '0;
      addrb_l   <= '0;
      rd_v1     <= 1'b0;
      rd_v2     <= 1'b0;
    end else begin
      rd_v2 <= rd_v1;
      if ((state == IDLE) || (state == GAP)) begin
        issue_ptr <= '0;
        rd_v1     <= 1'b0;
      end else if (issue) begin
        addrb_l   <= issue_ptr[AW-1:0];
        issue_ptr <= issue_ptr + 1'b1;
        rd_v1     <= 1'b1;
      end else begin
        rd_v1 <= 1'b0;
        if (addrb_l == AW'(PAGE_BYTES - 1)) begin
          addrb_l <= '0;
        end
      end
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    end
  end

  // FIFO storage write port.
  // NOTE: the FIFO storage is not reset; fifo_count gates every read, so stale contents are never observed.
  always_ff @(posedge rd_clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= power_out;
  end

  // Stream outputs decoded from registered state: header bytes MSB first,
  // then the FIFO head during the payload.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    tx_valid  = 1'b0;
    tx_data   = '0;
    tx_sof    = 1'b0;
    tx_eof    = 1'b0;
    hdr_shift = hdr_vec << {hdr_idx, 3'b000};
    unique case (state)
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_shift[HW-1 -: 8];
        tx_sof   = (hdr_idx == '0);
      end
      PAY: begin
        tx_valid = !fifo_empty;
        tx_data  = fifo_mem[rd_ptr];
        tx_eof   = !fifo_empty && (pay_cnt == (AW+1)'(PAGE_BYTES - 1));
      end
      default: ;
    endcase
  end

  // Overflow guard: the credit rule must keep every push within capacity.
  always_ff @(posedge rd_clk) begin
    if (!rst) begin
      assert (!(fifo_push && !fifo_pop && (fifo_count == CW'(FIFO_DEPTH))));
    end
  end

endmodule
